// File: rtl/rs_aged.sv
// Age-matrix reservation station: packed multi-lane dispatch, CDB wakeup with dispatch bypass,
// and combinational oldest-first selection onto ISSUE_W ports.
module rs_aged #(
  parameter int unsigned SIZE    = 16,
  parameter int unsigned DISP_W  = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned CDB_W   = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PRN_W   = 6,
  parameter int unsigned ROB_W   = 5,
  parameter int unsigned FUNC_W  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [DISP_W-1:0]             disp_valid,
  input  logic [DISP_W-1:0]             disp_op1_ready,
  input  logic [DISP_W-1:0]             disp_op2_ready,
  input  logic [DISP_W*DATA_W-1:0]      disp_op1,
  input  logic [DISP_W*DATA_W-1:0]      disp_op2,
  input  logic [DISP_W*FUNC_W-1:0]      disp_func,
  input  logic [DISP_W*PRN_W-1:0]       disp_dest_prn,
  input  logic [DISP_W*ROB_W-1:0]       disp_robn,
  input  logic [CDB_W-1:0]              cdb_valid,
  input  logic [CDB_W*PRN_W-1:0]        cdb_prn,
  input  logic [CDB_W*DATA_W-1:0]       cdb_value,
  input  logic [ISSUE_W-1:0]            iss_ready,
  output logic [ISSUE_W-1:0]            iss_valid,
  output logic [ISSUE_W*DATA_W-1:0]     iss_op1,
  output logic [ISSUE_W*DATA_W-1:0]     iss_op2,
  output logic [ISSUE_W*FUNC_W-1:0]     iss_func,
  output logic [ISSUE_W*PRN_W-1:0]      iss_dest_prn,
  output logic [ISSUE_W*ROB_W-1:0]      iss_robn,
  output logic                          almost_full,
  output logic [$clog2(SIZE+1)-1:0]     count
);

  localparam int unsigned CntW  = $clog2(SIZE + 1);
  localparam int unsigned IdxW  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned LaneW = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  logic [SIZE-1:0]   valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [SIZE-1:0]   older_q [SIZE];  // older_q[i][j]: entry i is older than entry j
  logic [SIZE-1:0]   older_d [SIZE];
  logic [DATA_W-1:0] op1_q [SIZE], op1_d [SIZE], op2_q [SIZE], op2_d [SIZE];
  logic [FUNC_W-1:0] func_q [SIZE], func_d [SIZE];
  logic [PRN_W-1:0]  dest_q [SIZE], dest_d [SIZE];
  logic [ROB_W-1:0]  robn_q [SIZE], robn_d [SIZE];
  logic [CntW-1:0]   count_q, count_d;

  // Dispatch operands after CDB bypass
  logic [DATA_W-1:0] byp_op1 [DISP_W], byp_op2 [DISP_W];
  logic [DISP_W-1:0] byp_rdy1, byp_rdy2;

  always_comb begin
    for (int l = 0; l < DISP_W; l++) begin
      byp_op1[l]  = disp_op1[l*DATA_W +: DATA_W];
      byp_op2[l]  = disp_op2[l*DATA_W +: DATA_W];
      byp_rdy1[l] = disp_op1_ready[l];
      byp_rdy2[l] = disp_op2_ready[l];
      // Descending scan so the lowest matching CDB lane wins
      for (int k = CDB_W - 1; k >= 0; k--) begin
        if (cdb_valid[k] && !disp_op1_ready[l] &&
            cdb_prn[k*PRN_W +: PRN_W] == disp_op1[l*DATA_W +: PRN_W]) begin
          byp_op1[l]  = cdb_value[k*DATA_W +: DATA_W];
          byp_rdy1[l] = 1'b1;
        end
        if (cdb_valid[k] && !disp_op2_ready[l] &&
            cdb_prn[k*PRN_W +: PRN_W] == disp_op2[l*DATA_W +: PRN_W]) begin
          byp_op2[l]  = cdb_value[k*DATA_W +: DATA_W];
          byp_rdy2[l] = 1'b1;
        end
      end
    end
  end

  // Allocation: lanes in ascending order take the lowest free slots
  logic              disp_en, found;
  logic [SIZE-1:0]   taken;
  logic [DISP_W-1:0] alloc_vld;
  logic [IdxW-1:0]   alloc_idx [DISP_W];
  logic [LaneW-1:0]  new_lane [SIZE];
  logic [CntW-1:0]   n_acc;

  always_comb begin
    disp_en   = ~almost_full & ~squash;
    found     = 1'b0;
    taken     = '0;
    alloc_vld = '0;
    n_acc     = '0;
    for (int l = 0; l < DISP_W; l++) alloc_idx[l] = '0;
    for (int i = 0; i < SIZE; i++) new_lane[i] = '0;
    for (int l = 0; l < DISP_W; l++) begin
      if (disp_en && disp_valid[l]) begin
        found = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
          if (!found && !valid_q[i] && !taken[i]) begin
            found        = 1'b1;
            taken[i]     = 1'b1;
            alloc_idx[l] = IdxW'(i);
            alloc_vld[l] = 1'b1;
            new_lane[i]  = LaneW'(l);
          end
        end
        if (found) n_acc = n_acc + CntW'(1);
      end
    end
  end

  // Selection: rank = number of older eligible entries; port p takes rank p
  logic [SIZE-1:0] elig, issue_mask;
  logic [CntW-1:0] rank [SIZE];
  logic [IdxW-1:0] sel;
  logic            hit;
  logic [CntW-1:0] n_iss;

  always_comb begin
    elig         = valid_q & rdy1_q & rdy2_q;
    iss_valid    = '0;
    iss_op1      = '0;
    iss_op2      = '0;
    iss_func     = '0;
    iss_dest_prn = '0;
    iss_robn     = '0;
    issue_mask   = '0;
    n_iss        = '0;
    sel          = '0;
    hit          = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      rank[i] = '0;
      for (int j = 0; j < SIZE; j++) begin
        if (elig[j] && older_q[j][i]) rank[i] = rank[i] + CntW'(1);
      end
    end
    for (int p = 0; p < ISSUE_W; p++) begin
      sel = '0;
      hit = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        if (elig[i] && rank[i] == CntW'(p)) begin
          hit = 1'b1;
          sel = IdxW'(i);
        end
      end
      hit                               = hit & ~squash;
      iss_valid[p]                      = hit;
      iss_op1[p*DATA_W +: DATA_W]       = op1_q[sel];
      iss_op2[p*DATA_W +: DATA_W]       = op2_q[sel];
      iss_func[p*FUNC_W +: FUNC_W]      = func_q[sel];
      iss_dest_prn[p*PRN_W +: PRN_W]    = dest_q[sel];
      iss_robn[p*ROB_W +: ROB_W]        = robn_q[sel];
      if (hit && iss_ready[p]) begin
        issue_mask[sel] = 1'b1;
        n_iss           = n_iss + CntW'(1);
      end
    end
  end

  // Next state: wakeup, dispatch write with age update, squash override
  logic [IdxW-1:0] n;

  always_comb begin
    valid_d = valid_q & ~issue_mask;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    older_d = older_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    func_d  = func_q;
    dest_d  = dest_q;
    robn_d  = robn_q;
    n       = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int k = CDB_W - 1; k >= 0; k--) begin
        if (valid_q[i] && !rdy1_q[i] && cdb_valid[k] &&
            cdb_prn[k*PRN_W +: PRN_W] == op1_q[i][PRN_W-1:0]) begin
          op1_d[i]  = cdb_value[k*DATA_W +: DATA_W];
          rdy1_d[i] = 1'b1;
        end
        if (valid_q[i] && !rdy2_q[i] && cdb_valid[k] &&
            cdb_prn[k*PRN_W +: PRN_W] == op2_q[i][PRN_W-1:0]) begin
          op2_d[i]  = cdb_value[k*DATA_W +: DATA_W];
          rdy2_d[i] = 1'b1;
        end
      end
    end
    for (int l = 0; l < DISP_W; l++) begin
      if (alloc_vld[l]) begin
        n         = alloc_idx[l];
        valid_d[n] = 1'b1;
        rdy1_d[n]  = byp_rdy1[l];
        rdy2_d[n]  = byp_rdy2[l];
        op1_d[n]   = byp_op1[l];
        op2_d[n]   = byp_op2[l];
        func_d[n]  = disp_func[l*FUNC_W +: FUNC_W];
        dest_d[n]  = disp_dest_prn[l*PRN_W +: PRN_W];
        robn_d[n]  = disp_robn[l*ROB_W +: ROB_W];
        for (int j = 0; j < SIZE; j++) begin
          if (taken[j]) begin
            older_d[n][j] = new_lane[j] > LaneW'(l);
            older_d[j][n] = new_lane[j] < LaneW'(l);
          end else begin
            older_d[n][j] = 1'b0;
            older_d[j][n] = 1'b1;
          end
        end
      end
    end
    count_d = count_q + n_acc - n_iss;
    if (squash) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      older_q <= '{default: '0};
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      older_q <= older_d;
      count_q <= count_d;
    end
  end

  // Payload carries no reset; it is qualified by valid/ready
  always_ff @(posedge clock) begin
    op1_q  <= op1_d;
    op2_q  <= op2_d;
    func_q <= func_d;
    dest_q <= dest_d;
    robn_q <= robn_d;
  end

  assign almost_full = count_q > CntW'(SIZE - DISP_W);
  assign count       = count_q;

endmodule

// File: tb/tb_rs_aged.sv
// Scoreboard bench for rs_aged: expected issues are queued at dispatch and compared on handshake.
module tb_rs_aged;
  localparam int unsigned SIZE = 8, DISP_W = 2, ISSUE_W = 2, CDB_W = 2;
  localparam int unsigned DATA_W = 32, PRN_W = 6, ROB_W = 5, FUNC_W = 4;

  logic                      clock, reset, squash;
  logic [DISP_W-1:0]         disp_valid, disp_op1_ready, disp_op2_ready;
  logic [DISP_W*DATA_W-1:0]  disp_op1, disp_op2;
  logic [DISP_W*FUNC_W-1:0]  disp_func;
  logic [DISP_W*PRN_W-1:0]   disp_dest_prn;
  logic [DISP_W*ROB_W-1:0]   disp_robn;
  logic [CDB_W-1:0]          cdb_valid;
  logic [CDB_W*PRN_W-1:0]    cdb_prn;
  logic [CDB_W*DATA_W-1:0]   cdb_value;
  logic [ISSUE_W-1:0]        iss_ready, iss_valid;
  logic [ISSUE_W*DATA_W-1:0] iss_op1, iss_op2;
  logic [ISSUE_W*FUNC_W-1:0] iss_func;
  logic [ISSUE_W*PRN_W-1:0]  iss_dest_prn;
  logic [ISSUE_W*ROB_W-1:0]  iss_robn;
  logic                      almost_full;
  logic [3:0]                count;

  rs_aged #(
    .SIZE(SIZE), .DISP_W(DISP_W), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W),
    .DATA_W(DATA_W), .PRN_W(PRN_W), .ROB_W(ROB_W), .FUNC_W(FUNC_W)
  ) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .disp_valid(disp_valid), .disp_op1_ready(disp_op1_ready), .disp_op2_ready(disp_op2_ready),
    .disp_op1(disp_op1), .disp_op2(disp_op2), .disp_func(disp_func),
    .disp_dest_prn(disp_dest_prn), .disp_robn(disp_robn),
    .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_value(cdb_value),
    .iss_ready(iss_ready), .iss_valid(iss_valid), .iss_op1(iss_op1), .iss_op2(iss_op2),
    .iss_func(iss_func), .iss_dest_prn(iss_dest_prn), .iss_robn(iss_robn),
    .almost_full(almost_full), .count(count)
  );

  typedef struct packed {
    logic [31:0] op1;
    logic [4:0]  robn;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one dispatch lane; op2 always ready, func/dest derived from robn
  task automatic lane(input int l, input logic r1, input logic [31:0] o1, input logic [4:0] rb);
    disp_valid[l]               = 1'b1;
    disp_op1_ready[l]           = r1;
    disp_op1[l*32 +: 32]        = o1;
    disp_op2_ready[l]           = 1'b1;
    disp_op2[l*32 +: 32]        = 32'h1000 + 32'(rb);
    disp_func[l*4 +: 4]         = rb[3:0];
    disp_dest_prn[l*6 +: 6]     = 6'(rb) + 6'd1;
    disp_robn[l*5 +: 5]         = rb;
  endtask

  task automatic push(input logic [31:0] o1, input logic [4:0] rb);
    exp_t e;
    e.op1  = o1;
    e.robn = rb;
    exp_q.push_back(e);
  endtask

  // Compare handshakes against the scoreboard, then advance one clock edge
  task automatic tick();
    exp_t e;
    #1;
    for (int p = 0; p < ISSUE_W; p++) begin
      if (iss_valid[p] && iss_ready[p]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("spurious_issue_p%0d", p), 64'(iss_robn[p*5 +: 5]), 64'h3f);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("p%0d_op1", p), 64'(iss_op1[p*32 +: 32]), 64'(e.op1));
          check($sformatf("p%0d_robn", p), 64'(iss_robn[p*5 +: 5]), 64'(e.robn));
          check($sformatf("p%0d_func", p), 64'(iss_func[p*4 +: 4]), 64'(e.robn[3:0]));
        end
      end
    end
    @(posedge clock);
    #1;
    disp_valid = '0;
    cdb_valid  = '0;
    squash     = 1'b0;
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0; squash = 1'b0;
    disp_valid = '0; disp_op1_ready = '0; disp_op2_ready = '0;
    disp_op1 = '0; disp_op2 = '0; disp_func = '0; disp_dest_prn = '0; disp_robn = '0;
    cdb_valid = '0; cdb_prn = '0; cdb_value = '0; iss_ready = '0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_af", 64'(almost_full), 64'd0);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    #20;
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;

    // Two ready lanes issue on both ports the following cycle
    iss_ready = 2'b11;
    lane(0, 1'b1, 32'hA0, 5'd1); push(32'hA0, 5'd1);
    lane(1, 1'b1, 32'hB0, 5'd2); push(32'hB0, 5'd2);
    tick();
    check("ab_valid", 64'(iss_valid), 64'b11);
    check("ab_p0_robn", 64'(iss_robn[4:0]), 64'd1);
    check("ab_p1_robn", 64'(iss_robn[9:5]), 64'd2);
    check("ab_count", 64'(count), 64'd2);
    tick();
    check("ab_count_after", 64'(count), 64'd0);

    // Fill to 7, then a blocked dispatch; lane1-only dispatch exercises packing
    iss_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      lane(0, 1'b1, 32'h300 + 32'(2*k), 5'(3 + 2*k)); push(32'h300 + 32'(2*k), 5'(3 + 2*k));
      lane(1, 1'b1, 32'h301 + 32'(2*k), 5'(4 + 2*k)); push(32'h301 + 32'(2*k), 5'(4 + 2*k));
      tick();
    end
    check("fill_count6", 64'(count), 64'd6);
    check("fill_af6", 64'(almost_full), 64'd0);
    lane(1, 1'b1, 32'h309, 5'd9); push(32'h309, 5'd9);
    tick();
    check("fill_count7", 64'(count), 64'd7);
    check("fill_af7", 64'(almost_full), 64'd1);
    lane(0, 1'b1, 32'h3F0, 5'd20);
    lane(1, 1'b1, 32'h3F1, 5'd21);
    tick();
    check("blocked_count", 64'(count), 64'd7);
    check("blocked_oldest", 64'(iss_robn[4:0]), 64'd3);
    iss_ready = 2'b11;
    repeat (4) tick();
    check("drain_count", 64'(count), 64'd0);
    check("drain_af", 64'(almost_full), 64'd0);

    // Dispatch bypass, then wakeup where two CDB lanes match (lowest wins)
    lane(0, 1'b0, 32'd5, 5'd10); push(32'hDEAD, 5'd10);
    lane(1, 1'b0, 32'd9, 5'd11);
    cdb_valid = 2'b01; cdb_prn = {6'd0, 6'd5}; cdb_value = {32'h0, 32'hDEAD};
    tick();
    check("byp_valid", 64'(iss_valid), 64'b01);
    check("byp_op1", 64'(iss_op1[31:0]), 64'hDEAD);
    cdb_valid = 2'b11; cdb_prn = {6'd9, 6'd9}; cdb_value = {32'h222, 32'h111};
    push(32'h111, 5'd11);
    tick();
    check("wake_valid", 64'(iss_valid), 64'b01);
    check("wake_op1", 64'(iss_op1[31:0]), 64'h111);
    tick();
    check("wake_count", 64'(count), 64'd0);

    // Partial acceptance keeps the rejected entry; issue and dispatch overlap
    iss_ready = 2'b00;
    lane(0, 1'b1, 32'hC0, 5'd12); push(32'hC0, 5'd12);
    lane(1, 1'b1, 32'hD0, 5'd13); push(32'hD0, 5'd13);
    tick();
    lane(0, 1'b1, 32'hE0, 5'd14); push(32'hE0, 5'd14);
    tick();
    check("cde_p0", 64'(iss_robn[4:0]), 64'd12);
    check("cde_p1", 64'(iss_robn[9:5]), 64'd13);
    iss_ready = 2'b01;
    tick();
    check("keep_valid", 64'(iss_valid), 64'b11);
    check("keep_p0", 64'(iss_robn[4:0]), 64'd13);
    check("keep_p1", 64'(iss_robn[9:5]), 64'd14);
    check("keep_count", 64'(count), 64'd2);
    iss_ready = 2'b11;
    lane(0, 1'b1, 32'hF0, 5'd15); push(32'hF0, 5'd15);
    tick();
    check("overlap_count", 64'(count), 64'd1);
    check("overlap_p0", 64'(iss_robn[4:0]), 64'd15);
    tick();
    check("overlap_drain", 64'(count), 64'd0);

    // Squash wins over a concurrent dispatch
    iss_ready = 2'b00;
    lane(0, 1'b1, 32'h160, 5'd16); lane(1, 1'b1, 32'h170, 5'd17);
    tick();
    lane(0, 1'b1, 32'h180, 5'd18); lane(1, 1'b1, 32'h190, 5'd19);
    tick();
    check("sq_count_before", 64'(count), 64'd4);
    iss_ready = 2'b11;
    squash = 1'b1;
    lane(0, 1'b1, 32'h220, 5'd22); lane(1, 1'b1, 32'h230, 5'd23);
    #1;
    check("sq_iss_masked", 64'(iss_valid), 64'b00);
    tick();
    check("sq_count", 64'(count), 64'd0);
    check("sq_iss_valid", 64'(iss_valid), 64'b00);

    // Asynchronous reset while entries are being presented
    lane(0, 1'b1, 32'h240, 5'd24); lane(1, 1'b1, 32'h250, 5'd25);
    tick();
    check("pre_rst_valid", 64'(iss_valid), 64'b11);
    #2 reset = 1'b0;
    #1;
    check("arst_iss_valid", 64'(iss_valid), 64'b00);
    check("arst_count", 64'(count), 64'd0);
    check("arst_af", 64'(almost_full), 64'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    lane(0, 1'b1, 32'h260, 5'd26); push(32'h260, 5'd26);
    tick();
    check("post_rst_valid", 64'(iss_valid), 64'b01);
    tick();
    check("post_rst_count", 64'(count), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rs_aged.md
RS_AGED -- requirements
Module: rs_aged

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  SIZE 16: entry count, >= DISP_W.
  DISP_W 2: dispatch lanes.
  ISSUE_W 2: issue ports.
  CDB_W 2: CDB broadcast lanes.
  DATA_W 32: operand width.
  PRN_W 6: physical register tag width.
  ROB_W 5: ROB index width.
  FUNC_W 4: opaque function code width.
REQ-002 SHALL have ports, one per line (name direction width meaning); the clock and reset ports come first:
  clock in 1: single clock, rising edge.
  reset in 1: asynchronous, active-low; 0 = reset.
  squash in 1: synchronous full flush.
  disp_valid in DISP_W: per-lane dispatch request.
  disp_op1_ready, disp_op2_ready in DISP_W each: operand holds a value (1) or a tag (0).
  disp_op1, disp_op2 in DISP_W*DATA_W each: value, or PRN tag in the low PRN_W bits when not ready.
  disp_func in DISP_W*FUNC_W, disp_dest_prn in DISP_W*PRN_W, disp_robn in DISP_W*ROB_W: carried unchanged to issue.
  cdb_valid in CDB_W, cdb_prn in CDB_W*PRN_W, cdb_value in CDB_W*DATA_W: result broadcast.
  iss_ready in ISSUE_W: per-port FU accept.
  iss_valid out ISSUE_W, plus iss_op1, iss_op2, iss_func, iss_dest_prn, iss_robn out (per port, matching widths): issue port.
  almost_full out 1: upstream SHALL NOT dispatch while high.
  count out clog2(SIZE+1): occupied entries.

Function
REQ-003 Entry state SHALL be: valid, op1/op2 ready flags, op1/op2, func, dest_prn, robn, and age relation vs every other entry (age matrix).
REQ-004 Dispatch: when almost_full=0 and squash=0, each lane with disp_valid=1 SHALL be written into a free entry; valid lanes SHALL take the lowest-index free entries in ascending lane order; sparse lanes are packed.
REQ-005 Dispatch while almost_full=1 SHALL be dropped entirely, with no partial acceptance.
REQ-006 Age order: every newly written entry SHALL be younger than all resident entries; within one cycle, the lower lane index SHALL be older.
REQ-007 Wakeup: a resident, not-ready operand whose tag equals cdb_prn[k] with cdb_valid[k]=1 SHALL have its value and ready flag set at the next edge.
REQ-008 Bypass: a lane dispatched in the same cycle as a matching CDB lane SHALL capture the CDB value and be written ready; no wakeup is lost.
REQ-009 If multiple CDB lanes match one operand, the lowest CDB index SHALL win.
REQ-010 Eligibility: valid and both operands ready, evaluated on registered state; an entry written at edge t is issuable in cycle t (zero-bubble after write).
REQ-011 Selection SHALL be combinational: port j presents the j-th oldest eligible entry; iss_valid[j]=0 if fewer than j+1 are eligible.
REQ-012 An entry SHALL be freed at the edge where its port has iss_valid=1 and iss_ready=1.
REQ-013 A non-accepted entry SHALL remain and be re-presented next cycle per current age order; port outputs SHALL be stable while no state changes.
REQ-014 count_next SHALL equal count + accepted - issued; it never exceeds SIZE nor underflows.
REQ-015 almost_full SHALL be (count > SIZE - DISP_W), from registered count.
REQ-016 Simultaneous issue and dispatch SHALL be allowed; a freed slot is not reused in the same cycle.
REQ-017 squash=1 SHALL clear all valid bits and set count=0 at the next edge, ignore that cycle's dispatch, and force iss_valid=0 in that cycle; squash has priority over all other events.

Reset
REQ-018 reset=0 SHALL immediately clear all entry valid bits, ready flags and the age matrix, and set count=0, almost_full=0 and iss_valid=0, independent of clock.
REQ-019 Deassertion SHALL take effect at the first edge after reset rises; assertion mid-operation discards all in-flight entries.

Verification (SIZE=8, DISP_W=2, ISSUE_W=2, CDB_W=2)
REQ-020 Dispatch A (lane0, ready) and B (lane1, ready), iss_ready=11 -> next cycle port0=A, port1=B; one cycle later count=0.
REQ-021 Fill to count=7 -> almost_full=1; disp_valid=11 -> count stays 7, no entry written.
REQ-022 Entry with op1 tag 5, cdb_valid=01, cdb_prn[0]=5, cdb_value=0xDEAD, in the same cycle as dispatch -> entry issues next cycle with op1=0xDEAD.
REQ-023 Entries dispatched in order C, D, E, all ready; iss_ready=01 -> C issues; port1 shows D with iss_valid=1 but D is kept; next cycle port0=D.
REQ-024 count=4; squash=1 together with disp_valid=11 -> next cycle count=0 and iss_valid=00; async reset=0 mid-issue -> iss_valid=00 before the next edge.
